// File: rtl/oven_zone_ctrl.sv
// Multi-zone oven controller: per-zone preheat/maintain FSM, setpoint and cook timer, shared seconds tick.
// Define OVEN_OVERTEMP_EN to add a per-zone FAULT state on over-temperature.

module oven_zone #(
  parameter int TEMP_W       = 9,
  parameter int TIME_W       = 12,
  parameter int ROOM_TEMP    = 65,
  parameter int DEFAULT_TEMP = 300,
  parameter int MIN_SET      = 100,
  parameter int MAX_TEMP     = 500,
  parameter int TEMP_STEP    = 50,
  parameter int TIME_STEP    = 30,
  parameter int MAX_TIME     = 3600,
  parameter int BAND         = 1,
  parameter int FAULT_MARGIN = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_on,
  input  logic              i_tick,
  input  logic              i_inc_temp,
  input  logic              i_dec_temp,
  input  logic              i_inc_time,
  input  logic              i_dec_time,
  output logic [TEMP_W-1:0] o_temp,
  output logic [TEMP_W-1:0] o_set,
  output logic [TIME_W-1:0] o_timer,
  output logic              o_heat,
  output logic              o_ready,
  output logic              o_done,
  output logic              o_fault
);
  // Two guard bits so sums and differences never wrap before saturation.
  localparam int TX = TEMP_W + 2;
  localparam int MX = TIME_W + 2;
  localparam logic [TX-1:0] L_ROOM  = TX'(ROOM_TEMP);
  localparam logic [TX-1:0] L_MIN   = TX'(MIN_SET);
  localparam logic [TX-1:0] L_MAX   = TX'(MAX_TEMP);
  localparam logic [TX-1:0] L_TSTEP = TX'(TEMP_STEP);
  localparam logic [TX-1:0] L_BAND  = TX'(BAND);
  localparam logic [MX-1:0] L_MSTEP = MX'(TIME_STEP);
  localparam logic [MX-1:0] L_MAXTM = MX'(MAX_TIME);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_PRE  = 2'd1,
    S_MAIN = 2'd2
`ifdef OVEN_OVERTEMP_EN
    , S_FAULT = 2'd3
`endif
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [TEMP_W-1:0] r_temp, r_set;
  logic [TIME_W-1:0] r_timer;
  logic              r_tog, r_done;
  logic              w_active, w_heat_up, w_cool, w_in_band, w_tick_dec;
  logic [TX-1:0]     w_temp_x, w_set_x, w_diff, w_sum, w_set_nxt;
  logic [MX-1:0]     w_tmr_x, w_dec1, w_tmr_nxt;

  assign w_temp_x  = TX'(r_temp);
  assign w_set_x   = TX'(r_set);
  assign w_diff    = (w_temp_x >= w_set_x) ? w_temp_x - w_set_x : w_set_x - w_temp_x;
  assign w_in_band = (w_diff <= L_BAND);
  assign w_active  = (r_state == S_PRE) || (r_state == S_MAIN);
  assign w_heat_up = w_active && (w_temp_x < w_set_x);
  // OFF and FAULT cool toward room temperature; active states cool only when at/above setpoint.
  assign w_cool    = w_active ? !w_heat_up : (w_temp_x > L_ROOM);
  assign w_sum     = w_temp_x + TX'(2);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_OFF:   if (i_on) w_state_nxt = S_PRE;
      S_PRE:   if (w_in_band) w_state_nxt = S_MAIN;
      S_MAIN:  if (!w_in_band) w_state_nxt = S_PRE;
      default: w_state_nxt = r_state;
    endcase
`ifdef OVEN_OVERTEMP_EN
    if (w_active && (w_temp_x > w_set_x + TX'(FAULT_MARGIN))) w_state_nxt = S_FAULT;
`endif
    if (!i_on) w_state_nxt = S_OFF;
  end

  always_comb begin
    w_set_nxt = w_set_x;
    if (i_inc_temp && !i_dec_temp)
      w_set_nxt = (w_set_x + L_TSTEP > L_MAX) ? L_MAX : w_set_x + L_TSTEP;
    else if (i_dec_temp && !i_inc_temp)
      w_set_nxt = (w_set_x < L_MIN + L_TSTEP) ? L_MIN : w_set_x - L_TSTEP;
  end

  assign w_tick_dec = i_tick && (r_state == S_MAIN) && (r_timer != '0);
  assign w_tmr_x    = MX'(r_timer);
  assign w_dec1     = MX'(w_tick_dec);

  // Adjust pulse and tick decrement combine into one net change before saturating.
  always_comb begin
    w_tmr_nxt = w_tmr_x - w_dec1;
    if (i_inc_time && !i_dec_time) begin
      w_tmr_nxt = w_tmr_x + L_MSTEP - w_dec1;
      if (w_tmr_nxt > L_MAXTM) w_tmr_nxt = L_MAXTM;
    end else if (i_dec_time && !i_inc_time) begin
      w_tmr_nxt = (w_tmr_x > L_MSTEP + w_dec1) ? w_tmr_x - L_MSTEP - w_dec1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_OFF;
      r_temp  <= TEMP_W'(ROOM_TEMP);
      r_set   <= TEMP_W'(DEFAULT_TEMP);
      r_timer <= '0;
      r_tog   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_set   <= w_set_nxt[TEMP_W-1:0];
      r_timer <= w_tmr_nxt[TIME_W-1:0];
      if (i_tick && w_heat_up) begin
        r_temp <= (w_sum > w_set_x) ? r_set : w_sum[TEMP_W-1:0];
      end else if (i_tick && w_cool) begin
        r_tog <= ~r_tog;
        if (r_tog) r_temp <= r_temp - TEMP_W'(1);
      end
      if (w_state_nxt == S_OFF || i_inc_time) r_done <= 1'b0;
      else if (w_tick_dec && r_timer == TIME_W'(1)) r_done <= 1'b1;
    end
  end

  assign o_temp  = r_temp;
  assign o_set   = r_set;
  assign o_timer = r_timer;
  assign o_heat  = w_active;
  assign o_ready = (r_state == S_MAIN);
  assign o_done  = r_done;
`ifdef OVEN_OVERTEMP_EN
  assign o_fault = (r_state == S_FAULT);
`else
  assign o_fault = 1'b0;
`endif
endmodule

module oven_zone_ctrl #(
  parameter int ZONES        = 2,
  parameter int TEMP_W       = 9,
  parameter int TIME_W       = 12,
  parameter int TICK_DIV     = 25000000,
  parameter int ROOM_TEMP    = 65,
  parameter int DEFAULT_TEMP = 300,
  parameter int MIN_SET      = 100,
  parameter int MAX_TEMP     = 500,
  parameter int TEMP_STEP    = 50,
  parameter int TIME_STEP    = 30,
  parameter int MAX_TIME     = 3600,
  parameter int BAND         = 1,
  parameter int FAULT_MARGIN = 25
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ZONES-1:0]        zone_on,
  input  logic [1:0]              sel_zone,
  input  logic                    inc_temp,
  input  logic                    dec_temp,
  input  logic                    inc_time,
  input  logic                    dec_time,
  output logic [ZONES*TEMP_W-1:0] temp_bus,
  output logic [ZONES-1:0]        heat,
  output logic [ZONES-1:0]        ready,
  output logic [ZONES-1:0]        done,
  output logic [ZONES-1:0]        fault,
  output logic [TEMP_W-1:0]       disp_temp,
  output logic [TEMP_W-1:0]       disp_set,
  output logic [TIME_W-1:0]       disp_time,
  output logic                    sec_tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] L_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0]                  r_tick_cnt;
  logic                           w_tick, w_sel_ok;
  logic [ZONES-1:0]               w_hit;
  logic [ZONES-1:0][TEMP_W-1:0]   w_temp, w_set;
  logic [ZONES-1:0][TIME_W-1:0]   w_timer;

  assign w_tick   = (r_tick_cnt == L_LAST);
  assign sec_tick = w_tick;
  assign w_sel_ok = (32'(sel_zone) < ZONES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + CW'(1);
  end

  for (genvar i = 0; i < ZONES; i++) begin : g_zone
    assign w_hit[i] = w_sel_ok && (sel_zone == 2'(i));
    oven_zone #(
      .TEMP_W(TEMP_W), .TIME_W(TIME_W), .ROOM_TEMP(ROOM_TEMP), .DEFAULT_TEMP(DEFAULT_TEMP),
      .MIN_SET(MIN_SET), .MAX_TEMP(MAX_TEMP), .TEMP_STEP(TEMP_STEP), .TIME_STEP(TIME_STEP),
      .MAX_TIME(MAX_TIME), .BAND(BAND), .FAULT_MARGIN(FAULT_MARGIN)
    ) u_zone (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_on       (zone_on[i]),
      .i_tick     (w_tick),
      .i_inc_temp (inc_temp & w_hit[i]),
      .i_dec_temp (dec_temp & w_hit[i]),
      .i_inc_time (inc_time & w_hit[i]),
      .i_dec_time (dec_time & w_hit[i]),
      .o_temp     (w_temp[i]),
      .o_set      (w_set[i]),
      .o_timer    (w_timer[i]),
      .o_heat     (heat[i]),
      .o_ready    (ready[i]),
      .o_done     (done[i]),
      .o_fault    (fault[i])
    );
  end

  assign temp_bus = w_temp;

  always_comb begin
    disp_temp = '0;
    disp_set  = '0;
    disp_time = '0;
    for (int z = 0; z < ZONES; z++) begin
      if (w_hit[z]) begin
        disp_temp = w_temp[z];
        disp_set  = w_set[z];
        disp_time = w_timer[z];
      end
    end
  end
endmodule

// File: tb/tb_oven_zone_ctrl.sv
// Scoreboard bench for oven_zone_ctrl: expectations queued with stimulus, popped at each sample point.
module tb_oven_zone_ctrl;
  localparam int ZONES = 2, TEMP_W = 9, TIME_W = 12, TICK_DIV = 4;
  localparam logic [3:0] P_IT = 4'b1000, P_DT = 4'b0100, P_ITM = 4'b0010, P_DTM = 4'b0001;

  logic                    clk = 1'b0, rst_n = 1'b0;
  logic [ZONES-1:0]        zone_on = '0;
  logic [1:0]              sel_zone = 2'd0;
  logic                    inc_temp = 1'b0, dec_temp = 1'b0, inc_time = 1'b0, dec_time = 1'b0;
  logic [ZONES*TEMP_W-1:0] temp_bus;
  logic [ZONES-1:0]        heat, ready, done, fault;
  logic [TEMP_W-1:0]       disp_temp, disp_set;
  logic [TIME_W-1:0]       disp_time;
  logic                    sec_tick;

  oven_zone_ctrl #(.ZONES(ZONES), .TEMP_W(TEMP_W), .TIME_W(TIME_W), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .zone_on(zone_on), .sel_zone(sel_zone),
    .inc_temp(inc_temp), .dec_temp(dec_temp), .inc_time(inc_time), .dec_time(dec_time),
    .temp_bus(temp_bus), .heat(heat), .ready(ready), .done(done), .fault(fault),
    .disp_temp(disp_temp), .disp_set(disp_set), .disp_time(disp_time), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  typedef enum int {S_T0, S_T1, S_DT, S_DS, S_DTM, S_HEAT, S_RDY, S_DONE, S_FLT, S_TICK} sig_e;
  typedef struct {
    string tag;
    sig_e  sig;
    int    val;
  } exp_t;

  exp_t sb_q[$];
  int   n_run = 0, n_fail = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_run++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int probe(input sig_e s);
    case (s)
      S_T0:    return int'(temp_bus[TEMP_W-1:0]);
      S_T1:    return int'(temp_bus[2*TEMP_W-1:TEMP_W]);
      S_DT:    return int'(disp_temp);
      S_DS:    return int'(disp_set);
      S_DTM:   return int'(disp_time);
      S_HEAT:  return int'(heat[0]);
      S_RDY:   return int'(ready[0]);
      S_DONE:  return int'(done[0]);
      S_FLT:   return int'(fault[0]);
      default: return int'(sec_tick);
    endcase
  endfunction

  task automatic expect_v(input string tag, input sig_e s, input int v);
    exp_t e;
    e.tag = tag; e.sig = s; e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk(e.tag, probe(e.sig), e.val);
    end
  endtask

  task automatic pulse(input logic [3:0] p);
    {inc_temp, dec_temp, inc_time, dec_time} = p;
    @(negedge clk);
    {inc_temp, dec_temp, inc_time, dec_time} = 4'b0;
  endtask

  // Returns at the negedge right after the tick's posedge (tick counter back at 0).
  task automatic wait_tick();
    int n;
    n = 0;
    while (sec_tick !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (sec_tick !== 1'b1) chk("tick_timeout", 0, 1);
    @(negedge clk);
  endtask

  // Drives a pulse into the same posedge that consumes a tick.
  task automatic pulse_at_tick(input logic [3:0] p);
    int n;
    n = 0;
    while (sec_tick !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (sec_tick !== 1'b1) chk("tick_timeout", 0, 1);
    pulse(p);
  endtask

  initial begin
    int n, tprev;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    expect_v("rst_t0", S_T0, 65);   expect_v("rst_t1", S_T1, 65);
    expect_v("rst_dt", S_DT, 65);   expect_v("rst_ds", S_DS, 300);
    expect_v("rst_dtm", S_DTM, 0);  expect_v("rst_heat", S_HEAT, 0);
    expect_v("rst_rdy", S_RDY, 0);  expect_v("rst_done", S_DONE, 0);
    expect_v("rst_flt", S_FLT, 0);  expect_v("rst_tick", S_TICK, 0);
    sb_check();
    rst_n = 1'b1;
    @(negedge clk);

    wait_tick();
    n = 0;
    while (sec_tick !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("tick_period", n, TICK_DIV - 1);
    @(negedge clk);

    // setpoint and timer saturation, simultaneous inc/dec
    for (int i = 1; i <= 6; i++) begin
      pulse(P_IT); expect_v("set_inc", S_DS, (300 + 50*i > 500) ? 500 : 300 + 50*i); sb_check();
    end
    for (int i = 1; i <= 8; i++) begin
      pulse(P_DT); expect_v("set_dec", S_DS, (500 - 50*i < 100) ? 100 : 500 - 50*i); sb_check();
    end
    pulse(P_IT | P_DT); expect_v("set_both", S_DS, 100); sb_check();
    repeat (4) pulse(P_IT);
    expect_v("set_back", S_DS, 300); sb_check();
    pulse(P_ITM | P_DTM); expect_v("tm_both", S_DTM, 0); sb_check();
    pulse(P_DTM);         expect_v("tm_floor", S_DTM, 0); sb_check();
    repeat (121) pulse(P_ITM);
    expect_v("tm_ceil", S_DTM, 3600); sb_check();
    repeat (120) pulse(P_DTM);
    expect_v("tm_zero", S_DTM, 0); sb_check();

    // zone isolation: zone 1 heats, adjusts go to zone 0 only
    wait_tick();
    zone_on = 2'b10; sel_zone = 2'd0;
    pulse(P_IT); pulse(P_ITM);
    expect_v("iso_ds0", S_DS, 350); expect_v("iso_dtm0", S_DTM, 30); sb_check();
    repeat (3) wait_tick();
    expect_v("iso_t1", S_T1, 71); expect_v("iso_t0", S_T0, 65); sb_check();
    sel_zone = 2'd1; #1;
    expect_v("iso_ds1", S_DS, 300); expect_v("iso_dtm1", S_DTM, 0); expect_v("iso_dt1", S_DT, 71);
    sb_check();
    @(negedge clk);
    sel_zone = 2'd2;
    pulse(P_IT | P_ITM); #1;
    expect_v("bad_dt", S_DT, 0); expect_v("bad_ds", S_DS, 0); expect_v("bad_dtm", S_DTM, 0);
    sb_check();
    sel_zone = 2'd0; #1;
    expect_v("bad_ds0", S_DS, 350); expect_v("bad_dtm0", S_DTM, 30); sb_check();
    @(negedge clk);
    pulse(P_DT); pulse(P_DTM);
    zone_on = 2'b00;

    // preheat 65 -> 299 with timer held at 60
    pulse(P_ITM); pulse(P_ITM);
    expect_v("tm60", S_DTM, 60); sb_check();
    wait_tick();
    zone_on = 2'b01;
    @(negedge clk);
    expect_v("pre_heat", S_HEAT, 1); sb_check();
    for (int k = 1; k <= 117; k++) begin
      wait_tick();
      expect_v("pre_temp", S_T0, 65 + 2*k); expect_v("pre_tm_hold", S_DTM, 60);
      expect_v("pre_rdy", S_RDY, 0); sb_check();
    end
    @(negedge clk);
    expect_v("main_rdy", S_RDY, 1); sb_check();

    // countdown in MAINTAIN
    for (int k = 1; k <= 60; k++) begin
      wait_tick();
      expect_v("cnt_tm", S_DTM, 60 - k); expect_v("cnt_done", S_DONE, (k == 60) ? 1 : 0);
      expect_v("cnt_rdy", S_RDY, 1); expect_v("cnt_flt", S_FLT, 0); sb_check();
      chk("temp_le_300", int'(temp_bus[TEMP_W-1:0] <= 9'd300), 1);
    end
    wait_tick();
    expect_v("hold_tm", S_DTM, 0); expect_v("hold_done", S_DONE, 1); sb_check();
    pulse(P_ITM);
    expect_v("clr_tm", S_DTM, 30); expect_v("clr_done", S_DONE, 0); sb_check();
    pulse_at_tick(P_ITM);
    expect_v("co_inc", S_DTM, 59); sb_check();
    pulse_at_tick(P_DTM);
    expect_v("co_dec", S_DTM, 28); sb_check();
    pulse_at_tick(P_DTM);
    expect_v("co_floor", S_DTM, 0); expect_v("co_done", S_DONE, 0); sb_check();

    // setpoint drop below temperature
    wait_tick();
    pulse(P_DT);
    @(negedge clk);
    expect_v("drop_ds", S_DS, 250); expect_v("drop_rdy", S_RDY, 0);
`ifdef OVEN_OVERTEMP_EN
    expect_v("drop_heat", S_HEAT, 0); expect_v("drop_flt", S_FLT, 1);
`else
    expect_v("drop_heat", S_HEAT, 1); expect_v("drop_flt", S_FLT, 0);
`endif
    sb_check();
    tprev = int'(temp_bus[TEMP_W-1:0]);
    repeat (4) wait_tick();
    expect_v("drop_cool", S_T0, tprev - 2); sb_check();
    zone_on = 2'b00;
    @(negedge clk);
    expect_v("off_heat", S_HEAT, 0); expect_v("off_flt", S_FLT, 0); sb_check();
    zone_on = 2'b01;
    @(negedge clk);
    expect_v("on_heat", S_HEAT, 1); expect_v("on_flt", S_FLT, 0); sb_check();
    pulse(P_IT);
    n = 0;
    while (ready[0] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    chk("ready_again", int'(ready[0]), 1);

    // finish a short cook, then reset mid-cook
    wait_tick();
    pulse(P_ITM);
    expect_v("cook_tm", S_DTM, 30); sb_check();
    repeat (30) wait_tick();
    expect_v("cook_done", S_DONE, 1); expect_v("cook_tm0", S_DTM, 0); sb_check();
    #2 rst_n = 1'b0;
    #1;
    expect_v("ar_heat", S_HEAT, 0); expect_v("ar_rdy", S_RDY, 0);
    expect_v("ar_done", S_DONE, 0); expect_v("ar_flt", S_FLT, 0);
    expect_v("ar_t0", S_T0, 65);    expect_v("ar_t1", S_T1, 65);
    expect_v("ar_ds", S_DS, 300);   expect_v("ar_dtm", S_DTM, 0);
    expect_v("ar_tick", S_TICK, 0);
    sb_check();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
